bus_terminal_fifo: RTL and testbench

- Per-device terminal buffer that sits directly between one device port of the bus generator/arbiter and its device-side logic.
- TX FIFO: presents pending packets to the bus through the pndng/pop/D_pop handshake.
- RX FIFO: absorbs packets the bus delivers through push/D_push and hands them to the device.
- One instance per driver slot; drvrs instances form the bus-facing pndng/pop/push arrays.

---
 rtl/bus_pkg.sv | 28 ++
 rtl/bus_terminal_fifo_if.sv | 34 +++
 rtl/bus_terminal_fifo_sync_fifo.sv | 79 +++++++
 rtl/bus_terminal_fifo.sv | 119 +++++++++++
 tb/tb_bus_terminal_fifo.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared constants for the bus terminal FIFO.
// Holds the destination-field geometry, the broadcast ID and the bit
// positions inside the sticky err_flags vector. The packet width is a
// module parameter, so each module declares its own pkt_t from it.
package bus_pkg;

  // The destination ID is the top byte of every packet.
  localparam int unsigned DEST_W = 8;

  // Destination field bounds for the default 16-bit packet.
  localparam int unsigned DEST_MSB = 15;
  localparam int unsigned DEST_LSB = 8;

  localparam logic [DEST_W-1:0] BROADCAST_ID = 8'hFF;

  // err_flags bit positions.
  localparam int unsigned ERR_W        = 4;
  localparam int unsigned ERR_TX_OVF   = 0;
  localparam int unsigned ERR_TX_UNF   = 1;
  localparam int unsigned ERR_RX_OVF   = 2;
  localparam int unsigned ERR_MISROUTE = 3;

  // Lowest bit of the destination field for a packet of the given width.
  function automatic int unsigned dest_lsb(input int unsigned pkt_w);
    return pkt_w - DEST_W;
  endfunction

endpackage

// File: rtl/bus_terminal_fifo_if.sv
// Bus-side handshake between the bus generator/arbiter and one terminal.
//   pndng  : terminal -> bus, TX FIFO non-empty
//   D_pop  : terminal -> bus, TX head packet (show-ahead)
//   pop    : bus -> terminal, consume TX head
//   push   : bus -> terminal, D_push valid this cycle
//   D_push : bus -> terminal, delivered packet
// master is the bus side, slave is the terminal side.
interface bus_terminal_fifo_if #(
  parameter int unsigned pckg_sz = 16
) ();

  logic               pndng;
  logic               pop;
  logic [pckg_sz-1:0] D_pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;

  modport master (
    input  pndng,
    input  D_pop,
    output pop,
    output push,
    output D_push
  );

  modport slave (
    output pndng,
    output D_pop,
    input  pop,
    input  push,
    input  D_push
  );

endinterface

// File: rtl/bus_terminal_fifo_sync_fifo.sv
// Single-clock show-ahead FIFO.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   wr_en      : write wr_data (accepted when not full, or when full and rd_en)
//   rd_en      : advance the head (ignored when empty)
//   rd_data    : head entry while not empty, zero otherwise
//   full/empty : occupancy flags, derived from the registered count
//   count      : occupancy, 0..Depth
//   ovf/unf    : single-cycle strobes for a dropped write / a read on empty
module bus_terminal_fifo_sync_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [Width-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [Width-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] count,
  output logic                       ovf,
  output logic                       unf
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic do_wr;
  logic do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(Depth));
  assign count = count_q;

  // A read frees a slot in the same edge, so a write while full is still
  // taken if the head is being consumed.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | rd_en);

  assign ovf = wr_en & full & ~rd_en;
  assign unf = rd_en & empty;

  // Gating by empty keeps stale storage off the output after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CntW'(do_wr) - CntW'(do_rd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/bus_terminal_fifo.sv
// Per-device terminal buffer between one bus port and its device logic.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   bus (slave modport)     : pndng/D_pop/pop towards the bus, push/D_push from it
//   dev_wr_en, dev_wr_data  : device writes a packet into the TX FIFO
//   dev_full                : TX FIFO full
//   dev_rd_en               : device consumes the RX head
//   dev_rd_data             : RX head packet (show-ahead)
//   dev_rd_valid            : RX FIFO non-empty
//   tx_cnt, rx_cnt          : FIFO occupancies
//   err_flags               : sticky {misroute, rx_ovf, tx_unf, tx_ovf}
//   clr_err                 : synchronous clear of err_flags (new events win)
module bus_terminal_fifo
  import bus_pkg::*;
#(
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned depth     = 8,
  parameter logic [7:0]  id        = 8'h00,
  parameter logic [7:0]  broadcast = BROADCAST_ID
) (
  input  logic                       clk,
  input  logic                       reset,
  bus_terminal_fifo_if.slave         bus,
  input  logic                       dev_wr_en,
  input  logic [pckg_sz-1:0]         dev_wr_data,
  output logic                       dev_full,
  input  logic                       dev_rd_en,
  output logic [pckg_sz-1:0]         dev_rd_data,
  output logic                       dev_rd_valid,
  output logic [$clog2(depth+1)-1:0] tx_cnt,
  output logic [$clog2(depth+1)-1:0] rx_cnt,
  output logic [ERR_W-1:0]           err_flags,
  input  logic                       clr_err
);

  typedef logic [pckg_sz-1:0] pkt_t;

  pkt_t tx_head;
  pkt_t rx_head;
  logic tx_empty, rx_empty;
  logic tx_ovf, tx_unf, rx_ovf;
  logic rx_full_unused;
  logic rx_unf_unused;

  logic [DEST_W-1:0] rx_dest;
  logic              rx_match;
  logic              rx_wr;
  logic              misroute;

  logic [ERR_W-1:0] err_set;
  logic [ERR_W-1:0] err_q, err_d;

  bus_terminal_fifo_sync_fifo #(
    .Width (pckg_sz),
    .Depth (depth)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (dev_wr_en),
    .wr_data (dev_wr_data),
    .rd_en   (bus.pop),
    .rd_data (tx_head),
    .full    (dev_full),
    .empty   (tx_empty),
    .count   (tx_cnt),
    .ovf     (tx_ovf),
    .unf     (tx_unf)
  );

  assign bus.pndng = ~tx_empty;
  assign bus.D_pop = tx_head;

  // Only packets addressed to this terminal or to everyone enter the RX FIFO.
  assign rx_dest  = bus.D_push[pckg_sz-1 -: DEST_W];
  assign rx_match = (rx_dest == id) || (rx_dest == broadcast);
  assign rx_wr    = bus.push & rx_match;
  assign misroute = bus.push & ~rx_match;

  bus_terminal_fifo_sync_fifo #(
    .Width (pckg_sz),
    .Depth (depth)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rx_wr),
    .wr_data (bus.D_push),
    .rd_en   (dev_rd_en),
    .rd_data (rx_head),
    .full    (rx_full_unused),
    .empty   (rx_empty),
    .count   (rx_cnt),
    .ovf     (rx_ovf),
    .unf     (rx_unf_unused)
  );

  assign dev_rd_data  = rx_head;
  assign dev_rd_valid = ~rx_empty;

  // Sticky error register; an event in the clear cycle survives the clear.
  always_comb begin
    err_set               = '0;
    err_set[ERR_TX_OVF]   = tx_ovf;
    err_set[ERR_TX_UNF]   = tx_unf;
    err_set[ERR_RX_OVF]   = rx_ovf;
    err_set[ERR_MISROUTE] = misroute;
    err_d = clr_err ? err_set : (err_q | err_set);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_flags = err_q;

endmodule

// File: tb/tb_bus_terminal_fifo.sv
module tb_bus_terminal_fifo;

  localparam int unsigned PKT   = 16;
  localparam int unsigned DEPTH = 8;
  localparam logic [7:0]  ID    = 8'h01;

  logic            clk;
  logic            reset;
  logic            dev_wr_en;
  logic [PKT-1:0]  dev_wr_data;
  logic            dev_full;
  logic            dev_rd_en;
  logic [PKT-1:0]  dev_rd_data;
  logic            dev_rd_valid;
  logic [3:0]      tx_cnt;
  logic [3:0]      rx_cnt;
  logic [3:0]      err_flags;
  logic            clr_err;

  bus_terminal_fifo_if #(.pckg_sz(PKT)) bif ();

  bus_terminal_fifo #(
    .pckg_sz   (PKT),
    .depth     (DEPTH),
    .id        (ID),
    .broadcast (8'hFF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bif),
    .dev_wr_en    (dev_wr_en),
    .dev_wr_data  (dev_wr_data),
    .dev_full     (dev_full),
    .dev_rd_en    (dev_rd_en),
    .dev_rd_data  (dev_rd_data),
    .dev_rd_valid (dev_rd_valid),
    .tx_cnt       (tx_cnt),
    .rx_cnt       (rx_cnt),
    .err_flags    (err_flags),
    .clr_err      (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: two packet queues plus the sticky error vector.
  logic [PKT-1:0] tx_q[$];
  logic [PKT-1:0] rx_q[$];
  logic [3:0]     err_m;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pndng"}, 32'(bif.pndng), 32'(tx_q.size() > 0));
    chk({tag, "_tx_cnt"}, 32'(tx_cnt), tx_q.size());
    chk({tag, "_dev_full"}, 32'(dev_full), 32'(tx_q.size() == DEPTH));
    chk({tag, "_rd_valid"}, 32'(dev_rd_valid), 32'(rx_q.size() > 0));
    chk({tag, "_rx_cnt"}, 32'(rx_cnt), rx_q.size());
    chk({tag, "_err"}, 32'(err_flags), 32'(err_m));
    if (tx_q.size() > 0) chk({tag, "_D_pop"}, 32'(bif.D_pop), 32'(tx_q[0]));
    if (rx_q.size() > 0) chk({tag, "_rd_data"}, 32'(dev_rd_data), 32'(rx_q[0]));
  endtask

  // Applies one cycle of the behavioural rules to the model.
  task automatic model_edge();
    logic [3:0]     set;
    logic [PKT-1:0] junk;
    logic [7:0]     dest;
    set = 4'h0;
    // TX: a pop frees a slot before the write is considered.
    if (bif.pop) begin
      if (tx_q.size() > 0) junk = tx_q.pop_front();
      else set[1] = 1'b1;
    end
    if (dev_wr_en) begin
      if (tx_q.size() < DEPTH) tx_q.push_back(dev_wr_data);
      else set[0] = 1'b1;
    end
    if (dev_rd_en && rx_q.size() > 0) junk = rx_q.pop_front();
    if (bif.push) begin
      dest = bif.D_push[15:8];
      if (dest == ID || dest == 8'hFF) begin
        if (rx_q.size() < DEPTH) rx_q.push_back(bif.D_push);
        else set[2] = 1'b1;
      end else begin
        set[3] = 1'b1;
      end
    end
    err_m = clr_err ? set : (err_m | set);
  endtask

  task automatic step(input logic wr, input logic [PKT-1:0] wd, input logic pp,
                      input logic ps, input logic [PKT-1:0] pd, input logic rd,
                      input logic clr, input string tag);
    dev_wr_en   = wr;
    dev_wr_data = wd;
    bif.pop     = pp;
    bif.push    = ps;
    bif.D_push  = pd;
    dev_rd_en   = rd;
    clr_err     = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, tag);
  endtask

  task automatic wr_tx(input logic [PKT-1:0] d, input logic pp, input string tag);
    step(1'b1, d, pp, 1'b0, '0, 1'b0, 1'b0, tag);
  endtask

  task automatic push_rx(input logic [PKT-1:0] d, input logic rd, input string tag);
    step(1'b0, '0, 1'b0, 1'b1, d, rd, 1'b0, tag);
  endtask

  initial begin
    logic [PKT-1:0] pd;
    logic [7:0]     dsel;
    int             wr_pct;

    reset       = 1'b1;
    dev_wr_en   = 1'b0;
    dev_wr_data = '0;
    bif.pop     = 1'b0;
    bif.push    = 1'b0;
    bif.D_push  = '0;
    dev_rd_en   = 1'b0;
    clr_err     = 1'b0;
    err_m       = 4'h0;

    // 1. Reset, idle, then reset in the middle of traffic.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("rst");
    chk("rst_D_pop", 32'(bif.D_pop), 32'h0);
    chk("rst_rd_data", 32'(dev_rd_data), 32'h0);
    idle("idle");
    wr_tx(16'h0111, 1'b0, "q0");
    wr_tx(16'h0122, 1'b0, "q1");
    push_rx(16'h0133, 1'b0, "q2");
    wr_tx(16'h0144, 1'b0, "q3");
    #2;
    reset = 1'b1;
    #1;
    tx_q.delete();
    rx_q.delete();
    err_m = 4'h0;
    check_all("midrst");
    chk("midrst_D_pop", 32'(bif.D_pop), 32'h0);
    chk("midrst_rd_data", 32'(dev_rd_data), 32'h0);
    dev_wr_en = 1'b0;
    bif.push  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle("postrst");
    chk("postrst_tx_cnt", 32'(tx_cnt), 32'h0);

    // 2. Two writes, two pops.
    wr_tx(16'h01AB, 1'b0, "t2w0");
    chk("t2_D_pop0", 32'(bif.D_pop), 32'h01AB);
    wr_tx(16'h01CD, 1'b0, "t2w1");
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, "t2p0");
    chk("t2_D_pop1", 32'(bif.D_pop), 32'h01CD);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, "t2p1");
    chk("t2_pndng", 32'(bif.pndng), 32'h0);

    // 3. TX full: drop without pop, accept with pop.
    for (int i = 0; i < DEPTH; i++) wr_tx(16'h0200 + 16'(i), 1'b0, "t3fill");
    wr_tx(16'hBEEF, 1'b0, "t3drop");
    chk("t3_tx_ovf", 32'(err_flags[0]), 32'h1);
    chk("t3_full", 32'(dev_full), 32'h1);
    wr_tx(16'hBEEF, 1'b1, "t3acc");
    chk("t3_tx_cnt", 32'(tx_cnt), 32'h8);
    for (int i = 0; i < DEPTH - 1; i++)
      step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, "t3drain");
    chk("t3_last", 32'(bif.D_pop), 32'hBEEF);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1, "t3pop_clr");

    // 4. Pop on empty, then pop-on-empty with a write.
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, "t4unf");
    chk("t4_tx_unf", 32'(err_flags[1]), 32'h1);
    wr_tx(16'h0011, 1'b1, "t4wp");
    chk("t4_tx_cnt", 32'(tx_cnt), 32'h1);
    chk("t4_D_pop", 32'(bif.D_pop), 32'h0011);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1, "t4pop_clr");

    // 5. RX filtering.
    push_rx(16'h0155, 1'b0, "t5p0");
    push_rx(16'hFF66, 1'b0, "t5p1");
    push_rx(16'h0277, 1'b0, "t5p2");
    chk("t5_rx_cnt", 32'(rx_cnt), 32'h2);
    chk("t5_misroute", 32'(err_flags[3]), 32'h1);
    chk("t5_rd0", 32'(dev_rd_data), 32'h0155);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, "t5r0");
    chk("t5_rd1", 32'(dev_rd_data), 32'hFF66);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, "t5r1");
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, "t5rd_empty_clr");
    chk("t5_clr", 32'(err_flags), 32'h0);

    // 6. RX overflow, then read and push together while full.
    for (int i = 0; i < DEPTH + 1; i++) push_rx(16'h0100 + 16'(i), 1'b0, "t6fill");
    chk("t6_rx_ovf", 32'(err_flags[2]), 32'h1);
    push_rx(16'h01EE, 1'b1, "t6rp");
    chk("t6_rx_cnt", 32'(rx_cnt), 32'h8);
    chk("t6_head", 32'(dev_rd_data), 32'h0101);
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, "t6drain");

    // Randomised traffic: a fill-biased phase then a drain-biased phase.
    for (int ph = 0; ph < 2; ph++) begin
      wr_pct = (ph == 0) ? 75 : 25;
      for (int n = 0; n < 250; n++) begin
        case ($urandom_range(0, 3))
          0:       dsel = ID;
          1:       dsel = 8'hFF;
          2:       dsel = 8'h02;
          default: dsel = 8'($urandom);
        endcase
        pd = {dsel, 8'($urandom)};
        step(($urandom_range(0, 99) < wr_pct), 16'($urandom),
             ($urandom_range(0, 99) >= wr_pct), ($urandom_range(0, 99) < wr_pct), pd,
             ($urandom_range(0, 99) >= wr_pct), ($urandom_range(0, 19) == 0), "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
